power_off_ctrl: RTL
===================

Name: power_off_ctrl

Overview:
Shutdown-side counterpart of the car's long-press power-on controller. While the car is powered on, it watches the power button for a debounced long press of HOLD_MS milliseconds and tracks user inactivity for IDLE_MS milliseconds. Either event issues a shutdown request to the top-level power latch. It sits beside the power-on controller and feeds the same latch.

Parameters:
CLK_FREQ, 100_000_000, input clock frequency in Hz; the ms divider period is CLK_FREQ/1000 cycles.
DEBOUNCE_MS, 20, number of consecutive ms ticks a raw button level must be stable before it is accepted.
HOLD_MS, 1000, hold time in ms that triggers a power-off.
IDLE_MS, 10000, inactivity time in ms that triggers an auto power-off.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
power_on  input  1  level from the power latch; 1 = car running
btn_off  input  1  raw, asynchronous power button
activity  input  1  any user command this cycle (level or pulse)
power_off  output  1  one-cycle pulse on entry to SHUTDOWN
shut_req  output  1  level; high throughout SHUTDOWN
cause  output  2  01 = long press, 10 = idle timeout, 00 = none; held until OFF
state  output  2  00 OFF, 01 ON, 10 HOLDING, 11 SHUTDOWN (debug/LED)

Behaviour:
- Reset: rst is sampled on the rising edge of clk. In the reset cycle: state = OFF; power_off = 0; shut_req = 0; cause = 00; divider, debounce, hold and idle counters = 0; armed = 0; debounced button = 0. All outputs are registered.
- ms_tick: internal one-cycle pulse every CLK_FREQ/1000 clk cycles from a free-running divider (count 0..N-1, tick when count = N-1). The divider runs in every state.
- Synchroniser: btn_off passes through 2 flip-flops before the debouncer. activity is used directly and must already be synchronous.
- Debounce: btn_db takes the synchronised level once that level has differed from btn_db for DEBOUNCE_MS consecutive ticks. Any bounce restarts the count.
- Counter widths are $clog2(limit+1). No counter may wrap; each saturates at its limit.
- OFF:
  - hold and idle counters are cleared; armed = 0.
  - When power_on = 1, go to ON next cycle.
- armed: set when btn_db = 0 is seen while in ON. This blocks the press that powered the car on from immediately powering it off.
- ON:
  - On each tick the idle counter increments; activity = 1 clears it, and clear takes priority over increment.
  - If btn_db = 1 and armed: go to HOLDING, clear the hold counter and clear the idle counter.
  - If a tick arrives with idle count = IDLE_MS-1 (and activity = 0): go to SHUTDOWN with cause = 10.
- HOLDING:
  - The hold counter increments per tick; the idle counter is held at 0.
  - If btn_db = 0 before the limit: return to ON, hold counter cleared.
  - If a tick arrives with hold count = HOLD_MS-1 and btn_db still 1: go to SHUTDOWN with cause = 01.
  - Release and expiry in the same cycle: release wins, return to ON.
- SHUTDOWN:
  - power_off = 1 only in the first cycle; shut_req = 1 for as long as the state lasts.
  - Further button presses or activity are ignored.
  - When power_on = 0, go to OFF next cycle; shut_req and cause clear in that cycle.
- power_on falling in ON or HOLDING: go to OFF next cycle; no power_off pulse; cause stays 00.
- Hold and idle reaching their limits on the same tick: cannot happen, because HOLDING holds the idle counter at 0. Cause priority, if ever needed: 01 over 10.
- rst asserted in any state, including mid-hold or in SHUTDOWN: return to the reset values in the next cycle. An in-progress pulse is truncated.

Test Plan:
All tests use CLK_FREQ=4000 (tick every 4 clk), DEBOUNCE_MS=2, HOLD_MS=10, IDLE_MS=50.
- Reset: hold rst 3 cycles with btn_off=1 and power_on=1 -> every output 0 and state=00 during reset; state=01 one cycle after rst falls.
- Power-on press still held: raise power_on with btn_off=1 for 30 ticks -> state stays 01, no HOLDING, because armed=0.
- Long press: release btn_off, then press for 15 ticks -> state=10 about 2 ticks after the press; power_off pulses exactly 1 cycle when the hold count expires; shut_req=1; cause=01. Drop power_on -> state=00 and shut_req=0 next cycle.
- Short press: press for 6 ticks then release -> HOLDING, then back to ON; no power_off.
- Bounce: toggle btn_off every 4 clk for 20 ticks -> btn_db never changes; no HOLDING.
- Idle: no activity for 50 ticks -> power_off pulses and cause=10. Then repeat with an activity pulse at tick 49 -> no shutdown until a further 50 idle ticks.
- Mid-operation: power_on drops during HOLDING -> state=00 with no pulse. rst asserted during SHUTDOWN -> shut_req=0 and cause=00 next cycle.

Source files
------------

// File: rtl/power_off_ctrl.sv
// power_off_ctrl: shutdown-side companion of the long-press power-on controller.
// While the car runs it watches for a debounced long press of the power button
// or a period of user inactivity, and requests the power latch to drop.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// OFF (00)   | car not running; counters cleared, waiting for power_on
// ON (01)    | car running; idle timer counting, waiting for an armed press
// HOLDING(10)| button held; hold timer counting towards power-off
// SHUTDOWN(11)| shutdown requested; shut_req held until power_on drops

module power_off_ctrl #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int HOLD_MS     = 1000,
    parameter int IDLE_MS     = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_on,
    input  logic       btn_off,
    input  logic       activity,
    output logic       power_off,
    output logic       shut_req,
    output logic [1:0] cause,
    output logic [1:0] state
);

    localparam int DIV_N  = CLK_FREQ / 1000;
    localparam int DIV_W  = $clog2(DIV_N + 1);
    localparam int DB_W   = $clog2(DEBOUNCE_MS + 1);
    localparam int HOLD_W = $clog2(HOLD_MS + 1);
    localparam int IDLE_W = $clog2(IDLE_MS + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV_N - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_MS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MS - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_MS - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_MS);

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_PRESS = 2'b01;
    localparam logic [1:0] CAUSE_IDLE  = 2'b10;

    typedef enum logic [1:0] {
        ST_OFF      = 2'b00,
        ST_ON       = 2'b01,
        ST_HOLDING  = 2'b10,
        ST_SHUTDOWN = 2'b11
    } state_t;

    state_t              st;
    logic [DIV_W-1:0]    div_cnt;
    logic                ms_tick;
    logic                btn_s1;
    logic                btn_s2;
    logic [DB_W-1:0]     db_cnt;
    logic                btn_db;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [IDLE_W-1:0]   idle_cnt;
    logic                armed;

    assign ms_tick = (div_cnt == DIV_LAST);
    assign state   = st;

    // Free-running millisecond divider, active in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (ms_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Two-flop synchroniser for the raw button.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            btn_s1 <= btn_off;
            btn_s2 <= btn_s1;
        end
    end

    // Debouncer: accept the new level after DEBOUNCE_MS consecutive ticks of disagreement.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt <= '0;
            btn_db <= 1'b0;
        end else if (btn_s2 == btn_db) begin
            db_cnt <= '0;
        end else if (ms_tick) begin
            if (db_cnt == DB_LAST) begin
                btn_db <= btn_s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Power-off FSM with hold/idle timers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= ST_OFF;
            hold_cnt  <= '0;
            idle_cnt  <= '0;
            armed     <= 1'b0;
            power_off <= 1'b0;
            shut_req  <= 1'b0;
            cause     <= CAUSE_NONE;
        end else begin
            power_off <= 1'b0;
            case (st)
                ST_OFF: begin
                    hold_cnt <= '0;
                    idle_cnt <= '0;
                    armed    <= 1'b0;
                    shut_req <= 1'b0;
                    cause    <= CAUSE_NONE;
                    if (power_on) begin
                        st <= ST_ON;
                    end
                end
                ST_ON: begin
                    if (!power_on) begin
                        st <= ST_OFF;
                    end else begin
                        // The press that woke the car must be released before it counts.
                        if (!btn_db) begin
                            armed <= 1'b1;
                        end
                        if (btn_db && armed) begin
                            st       <= ST_HOLDING;
                            hold_cnt <= '0;
                            idle_cnt <= '0;
                        end else if (activity) begin
                            idle_cnt <= '0;
                        end else if (ms_tick) begin
                            if (idle_cnt == IDLE_LAST) begin
                                st        <= ST_SHUTDOWN;
                                power_off <= 1'b1;
                                shut_req  <= 1'b1;
                                cause     <= CAUSE_IDLE;
                            end else if (idle_cnt != IDLE_MAX) begin
                                idle_cnt <= idle_cnt + 1'b1;
                            end
                        end
                    end
                end
                ST_HOLDING: begin
                    idle_cnt <= '0;
                    if (!power_on) begin
                        st <= ST_OFF;
                    end else if (!btn_db) begin
                        st       <= ST_ON;
                        hold_cnt <= '0;
                    end else if (ms_tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            st        <= ST_SHUTDOWN;
                            power_off <= 1'b1;
                            shut_req  <= 1'b1;
                            cause     <= CAUSE_PRESS;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                ST_SHUTDOWN: begin
                    shut_req <= 1'b1;
                    if (!power_on) begin
                        st       <= ST_OFF;
                        shut_req <= 1'b0;
                        cause    <= CAUSE_NONE;
                    end
                end
                default: begin
                    st <= ST_OFF;
                end
            endcase
        end
    end

endmodule
